dpram_port_arbiter: RTL and testbench

- Shares DPRAM port A between two requesters.
- M0 is the Modbus function/register handler; M1 is the local application/host side.
- Round-robin arbitration, optional lock for read-modify-write sequences, and a fixed-latency request/ack handshake.
- Port B of the DPRAM stays private to its own user and is outside this block.

---
 rtl/dpram_port_arbiter_if.sv | 37 +++
 rtl/dpram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_dpram_port_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dpram_port_arbiter_if.sv
// Bundle between the two DPRAM port-A requesters, the arbiter and the DPRAM port A itself.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface dpram_port_arbiter_if #(
    parameter int A_WIDTH = 4,
    parameter int D_WIDTH = 16
);
    logic               req0;
    logic               req1;
    logic               we0;
    logic               we1;
    logic               lock0;
    logic               lock1;
    logic [A_WIDTH-1:0] addr0;
    logic [A_WIDTH-1:0] addr1;
    logic [D_WIDTH-1:0] wdata0;
    logic [D_WIDTH-1:0] wdata1;
    logic               ack0;
    logic               ack1;
    logic [D_WIDTH-1:0] rdata0;
    logic [D_WIDTH-1:0] rdata1;
    logic               port_en;
    logic               port_we;
    logic [A_WIDTH-1:0] port_addr;
    logic [D_WIDTH-1:0] port_di;
    logic [D_WIDTH-1:0] port_do;
    logic               busy;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, port_do,
        output ack0, ack1, rdata0, rdata1, port_en, port_we, port_addr, port_di, busy
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, port_do,
        input  ack0, ack1, rdata0, rdata1, port_en, port_we, port_addr, port_di, busy
    );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing DPRAM port A between M0 (Modbus handler) and M1 (host side),
// with an owner lock for read-modify-write sequences and a fixed 2-cycle grant-to-ack latency.
//
//  state | meaning
//  IDLE  | arbitrate; on a grant drive the RAM port and move to ISSUE
//  ISSUE | PORT_EN high, DPRAM samples at the end of this cycle
//  RESP  | ACK to the selected requester, RDATA passes PORT_DO through
module dpram_port_arbiter #(
    parameter int A_WIDTH = 4,
    parameter int D_WIDTH = 16
) (
    input logic                 clock,
    input logic                 reset_n,
    dpram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state;
    logic               sel;
    logic               last_gnt;
    logic               lock_valid;
    logic               lock_owner;
    logic               lock_pending;
    logic               port_en_q;
    logic               port_we_q;
    logic [A_WIDTH-1:0] port_addr_q;
    logic [D_WIDTH-1:0] port_di_q;
    logic               ack0_q;
    logic               ack1_q;
    logic               busy_q;

    logic               owner_req;
    logic               gnt_valid;
    logic               gnt;

    // A lock only wins while its owner is still requesting; otherwise it is ignored this cycle
    // and cleared at the edge.
    always_comb begin
        owner_req = lock_owner ? bus.req1 : bus.req0;
        gnt_valid = 1'b0;
        gnt       = 1'b0;
        if (lock_valid && owner_req) begin
            gnt_valid = 1'b1;
            gnt       = lock_owner;
        end else if (bus.req0 && bus.req1) begin
            gnt_valid = 1'b1;
            gnt       = ~last_gnt;
        end else if (bus.req0) begin
            gnt_valid = 1'b1;
            gnt       = 1'b0;
        end else if (bus.req1) begin
            gnt_valid = 1'b1;
            gnt       = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            sel          <= 1'b0;
            last_gnt     <= 1'b1;
            lock_valid   <= 1'b0;
            lock_owner   <= 1'b0;
            lock_pending <= 1'b0;
            port_en_q    <= 1'b0;
            port_we_q    <= 1'b0;
            port_addr_q  <= '0;
            port_di_q    <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lock_valid && !owner_req) begin
                        lock_valid <= 1'b0;
                    end
                    if (gnt_valid) begin
                        sel          <= gnt;
                        last_gnt     <= gnt;
                        port_en_q    <= 1'b1;
                        port_we_q    <= gnt ? bus.we1    : bus.we0;
                        port_addr_q  <= gnt ? bus.addr1  : bus.addr0;
                        port_di_q    <= gnt ? bus.wdata1 : bus.wdata0;
                        lock_pending <= gnt ? bus.lock1  : bus.lock0;
                        busy_q       <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    port_en_q <= 1'b0;
                    port_we_q <= 1'b0;
                    ack0_q    <= ~sel;
                    ack1_q    <= sel;
                    state     <= RESP;
                end
                RESP: begin
                    ack0_q     <= 1'b0;
                    ack1_q     <= 1'b0;
                    lock_valid <= lock_pending;
                    lock_owner <= sel;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.port_en   = port_en_q;
    assign bus.port_we   = port_we_q;
    assign bus.port_addr = port_addr_q;
    assign bus.port_di   = port_di_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.busy      = busy_q;
    assign bus.rdata0    = ack0_q ? bus.port_do : '0;
    assign bus.rdata1    = ack1_q ? bus.port_do : '0;
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a small registered-output DPRAM model on port A.
module tb_dpram_port_arbiter;
    localparam int A_WIDTH = 4;
    localparam int D_WIDTH = 16;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    logic [D_WIDTH-1:0] mem [0:(1<<A_WIDTH)-1];

    dpram_port_arbiter_if #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) bus ();

    dpram_port_arbiter #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Read-after-write DPRAM port: DO is registered and shows written data on a write.
    always @(posedge clock) begin
        if (bus.port_en) begin
            if (bus.port_we) begin
                mem[bus.port_addr] <= bus.port_di;
                bus.port_do        <= bus.port_di;
            end else begin
                bus.port_do <= mem[bus.port_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [A_WIDTH-1:0] obs, input logic [A_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [D_WIDTH-1:0] obs, input logic [D_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < (1 << A_WIDTH); i++) mem[i] = '0;
        mem[5] = 16'h1234;
        mem[7] = 16'h0077;
        bus.port_do = '0;
        reset_n    = 1'b0;
        bus.req0   = 1'b0;  bus.req1   = 1'b0;
        bus.we0    = 1'b0;  bus.we1    = 1'b0;
        bus.lock0  = 1'b0;  bus.lock1  = 1'b0;
        bus.addr0  = '0;    bus.addr1  = '0;
        bus.wdata0 = '0;    bus.wdata1 = '0;

        // reset state
        tick(); tick();
        chk1("rst_ack0", bus.ack0, 1'b0);
        chk1("rst_ack1", bus.ack1, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_en", bus.port_en, 1'b0);
        chk1("rst_we", bus.port_we, 1'b0);
        chka("rst_addr", bus.port_addr, 4'h0);
        chkd("rst_di", bus.port_di, 16'h0000);
        reset_n = 1'b1;
        tick();

        // single read by M1
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd5;
        tick();
        chk1("rd_en", bus.port_en, 1'b1);
        chk1("rd_we", bus.port_we, 1'b0);
        chka("rd_addr", bus.port_addr, 4'd5);
        chk1("rd_busy", bus.busy, 1'b1);
        chk1("rd_ack1_early", bus.ack1, 1'b0);
        tick();
        chk1("rd_ack1", bus.ack1, 1'b1);
        chkd("rd_rdata1", bus.rdata1, 16'h1234);
        chk1("rd_ack0", bus.ack0, 1'b0);
        chkd("rd_rdata0", bus.rdata0, 16'h0000);
        chk1("rd_en_off", bus.port_en, 1'b0);
        bus.req1 = 1'b0;
        tick();
        chk1("rd_ack1_off", bus.ack1, 1'b0);
        chk1("rd_busy_off", bus.busy, 1'b0);

        // M0 write then M1 readback
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd3; bus.wdata0 = 16'hBEEF;
        tick();
        chk1("wr_we", bus.port_we, 1'b1);
        chkd("wr_di", bus.port_di, 16'hBEEF);
        tick();
        chk1("wr_ack0", bus.ack0, 1'b1);
        chkd("wr_rdata0", bus.rdata0, 16'hBEEF);
        bus.req0 = 1'b0; bus.we0 = 1'b0;
        tick();
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd3;
        tick(); tick();
        chk1("rb_ack1", bus.ack1, 1'b1);
        chkd("rb_rdata1", bus.rdata1, 16'hBEEF);
        bus.req1 = 1'b0;
        tick();

        // contention after reset: M0, M1, M0, M1
        reset_n = 1'b0;
        bus.req0 = 1'b1; bus.addr0 = 4'd5; bus.we0 = 1'b0;
        bus.req1 = 1'b1; bus.addr1 = 4'd3; bus.we1 = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("cn_busy", bus.busy, 1'b1);
            tick();
            chk1("cn_ack0", bus.ack0, (i % 2) == 0);
            chk1("cn_ack1", bus.ack1, (i % 2) == 1);
            chkd("cn_rdata", (i % 2) == 0 ? bus.rdata0 : bus.rdata1,
                 (i % 2) == 0 ? 16'h1234 : 16'hBEEF);
            tick();
            chk1("cn_idle", bus.busy, 1'b0);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();

        // lock: M1 read-modify-write of addr 7 while M0 waits
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd7; bus.lock1 = 1'b1;
        tick();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd5;
        tick();
        chk1("lk_ack1_rd", bus.ack1, 1'b1);
        chkd("lk_rdata1_rd", bus.rdata1, 16'h0077);
        bus.we1 = 1'b1; bus.lock1 = 1'b0; bus.wdata1 = 16'h5A5A;
        tick();
        tick();
        chka("lk_addr_wr", bus.port_addr, 4'd7);
        chk1("lk_we_wr", bus.port_we, 1'b1);
        tick();
        chk1("lk_ack1_wr", bus.ack1, 1'b1);
        chk1("lk_ack0_wr", bus.ack0, 1'b0);
        chkd("lk_rdata1_wr", bus.rdata1, 16'h5A5A);
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        tick();
        tick();
        chka("lk_m0_addr", bus.port_addr, 4'd5);
        tick();
        chk1("lk_m0_ack", bus.ack0, 1'b1);
        chkd("lk_m0_rdata", bus.rdata0, 16'h1234);
        bus.req0 = 1'b0;
        tick();

        // lock release by an idle cycle of the owner
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd3; bus.lock0 = 1'b1;
        tick();
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd5;
        tick();
        chk1("rl_ack0", bus.ack0, 1'b1);
        chkd("rl_rdata0", bus.rdata0, 16'hBEEF);
        bus.req0 = 1'b0; bus.lock0 = 1'b0;
        tick();
        tick();
        chk1("rl_busy", bus.busy, 1'b1);
        chka("rl_m1_addr", bus.port_addr, 4'd5);
        tick();
        chk1("rl_ack1", bus.ack1, 1'b1);
        chkd("rl_rdata1", bus.rdata1, 16'h1234);
        bus.req1 = 1'b0;
        tick();

        // reset during ISSUE aborts without ack
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd9; bus.wdata0 = 16'hDEAD;
        tick();
        chk1("ra_issue_en", bus.port_en, 1'b1);
        reset_n = 1'b0;
        tick();
        chk1("ra_ack0", bus.ack0, 1'b0);
        chk1("ra_busy", bus.busy, 1'b0);
        chk1("ra_en", bus.port_en, 1'b0);
        chka("ra_addr", bus.port_addr, 4'h0);
        chkd("ra_di", bus.port_di, 16'h0000);
        bus.we0 = 1'b0; bus.addr0 = 4'd3;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd5;
        tick();
        chk1("ra_ack0_hold", bus.ack0, 1'b0);
        reset_n = 1'b1;
        tick();
        chka("ra_first_addr", bus.port_addr, 4'd3);
        tick();
        chk1("ra_first_ack0", bus.ack0, 1'b1);
        chk1("ra_first_ack1", bus.ack1, 1'b0);
        chkd("ra_first_rdata0", bus.rdata0, 16'hBEEF);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
